// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter that time-shares one free-running multicycle AES-128 core
// among N_REQ requesters, buffering the single result until its owner takes it.

module aes_core_arbiter_lane #(
   parameter int ID_W = 2,
   parameter int LANE = 0
) (
   input  logic            done,
   input  logic [ID_W-1:0] grant_id,
   input  logic            granted,
   input  logic            issue_ok,
   input  logic            resp_ready,
   output logic            req_ready,
   output logic            resp_valid,
   output logic            handshake
);
   logic owner;

   // Only the owner of the buffered result sees valid, and only its ready frees the buffer.
   assign owner      = (grant_id == ID_W'(LANE));
   assign resp_valid = done & owner;
   assign handshake  = resp_valid & resp_ready;
   assign req_ready  = issue_ok & granted;
endmodule

module aes_core_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*128-1:0]  req_data,
   input  logic [N_REQ*128-1:0]  req_key,
   output logic [N_REQ-1:0]      resp_valid,
   input  logic [N_REQ-1:0]      resp_ready,
   output logic [127:0]          resp_data,
   input  logic                  core_ready,
   input  logic                  core_valid,
   input  logic [127:0]          core_out_bus,
   output logic [127:0]          core_in_bus,
   output logic [127:0]          core_key,
   output logic                  busy,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic [15:0]           skip_cnt
);
   localparam int ID_W = $clog2(N_REQ);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   gidx;
   logic [ID_W-1:0]   sel;
   logic [ID_W-1:0]   next_ptr;
   logic [ID_W:0]     scan;
   logic              found;
   logic              any_req;
   logic              hs;
   logic              issue_ok;
   logic [N_REQ-1:0]  grant;
   logic [N_REQ-1:0]  hs_vec;

   assign any_req = |req_valid;
   assign busy    = (state != IDLE);

   // Rotating priority scan starting at rr_ptr; scan is one bit wider so the wrap is a subtract.
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      scan  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (scan >= (ID_W+1)'(N_REQ))
            scan = scan - (ID_W+1)'(N_REQ);
         if (!found && req_valid[scan[ID_W-1:0]]) begin
            found = 1'b1;
            gidx  = scan[ID_W-1:0];
         end
      end
   end

   always_comb begin
      grant = '0;
      if (found)
         grant[gidx] = 1'b1;
   end

   assign sel         = found ? gidx : rr_ptr;
   assign core_in_bus = req_data[128*sel +: 128];
   assign core_key    = req_key[128*sel +: 128];
   assign next_ptr    = (gidx == ID_W'(N_REQ-1)) ? '0 : gidx + 1'b1;

   assign hs       = |hs_vec;
   assign issue_ok = ~rst & core_ready & any_req &
                     ((state == IDLE) | ((state == DONE) & hs));

   for (genvar i = 0; i < N_REQ; i++) begin : g_lane
      aes_core_arbiter_lane #(.ID_W(ID_W), .LANE(i)) u_lane (
         .done       (state == DONE),
         .grant_id   (grant_id),
         .granted    (grant[i]),
         .issue_ok   (issue_ok),
         .resp_ready (resp_ready[i]),
         .req_ready  (req_ready[i]),
         .resp_valid (resp_valid[i]),
         .handshake  (hs_vec[i])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_id  <= '0;
         resp_data <= '0;
         skip_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (issue_ok) begin
                  state    <= RUN;
                  grant_id <= gidx;
                  rr_ptr   <= next_ptr;
               end
            end
            RUN: begin
               if (core_valid) begin
                  resp_data <= core_out_bus;
                  state     <= DONE;
               end
            end
            DONE: begin
               // core_valid here is the bubble result of a period with no job; ignore it.
               if (hs) begin
                  if (issue_ok) begin
                     state    <= RUN;
                     grant_id <= gidx;
                     rr_ptr   <= next_ptr;
                  end else begin
                     state <= IDLE;
                  end
               end else if (core_ready && any_req) begin
                  if (skip_cnt != 16'hFFFF)
                     skip_cnt <= skip_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
